// File: rtl/kb_scan_controller.sv
// rtl/kb_scan_controller.sv - PS2 Set-2 scan-code sequencer with case adjust and show-ahead FIFO (optional caps lock: KB_CAPS_LOCK_EN)
module kb_scan_controller #(
    parameter int FIFO_ADDR_W = 2
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic [7:0] i_scan_code,
    input  logic       i_scan_done,
    output logic [7:0] o_key_code,
    input  logic [7:0] i_ascii_code,
    input  logic       i_rd,
    output logic [7:0] o_ascii,
    output logic       o_empty,
    output logic       o_full,
    output logic       o_overflow
);

    localparam int DEPTH = 1 << FIFO_ADDR_W;
    localparam logic [FIFO_ADDR_W-1:0] PTR_ONE    = FIFO_ADDR_W'(1);
    localparam logic [FIFO_ADDR_W:0]   CNT_ONE    = (FIFO_ADDR_W+1)'(1);
    localparam logic [FIFO_ADDR_W:0]   CNT_FULL   = (FIFO_ADDR_W+1)'(DEPTH);
    localparam logic [FIFO_ADDR_W:0]   CNT_EMPTY  = '0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BRK,
        ST_EXT,
        ST_EXT_BRK
    } state_t;

    state_t r_state;
    state_t w_next_state;

    logic       r_lshift;
    logic       r_rshift;
    logic       r_push_pend;
    logic [7:0] r_key_code;
    logic       r_overflow;

    logic [7:0]             r_mem [DEPTH];
    logic [FIFO_ADDR_W-1:0] r_wr_ptr;
    logic [FIFO_ADDR_W-1:0] r_rd_ptr;
    logic [FIFO_ADDR_W:0]   r_count;

    logic       w_load_key;
    logic       w_set_lshift;
    logic       w_set_rshift;
    logic       w_clr_lshift;
    logic       w_clr_rshift;
    logic       w_shift;
    logic [7:0] w_push_data;
    logic       w_full;
    logic       w_empty;
    logic       w_pop;
    logic       w_push;
    logic       w_drop;

`ifdef KB_CAPS_LOCK_EN
    logic r_caps;
    logic r_caps_held;
    logic w_caps_make;
    logic w_caps_brk;
`endif

    // Prefix tracking: decode each strobed byte against the current prefix state.
    always_comb begin
        w_next_state = r_state;
        w_load_key   = 1'b0;
        w_set_lshift = 1'b0;
        w_set_rshift = 1'b0;
        w_clr_lshift = 1'b0;
        w_clr_rshift = 1'b0;
`ifdef KB_CAPS_LOCK_EN
        w_caps_make  = 1'b0;
        w_caps_brk   = 1'b0;
`endif
        if (i_scan_done) begin
            case (r_state)
                ST_IDLE: begin
                    if (i_scan_code == 8'hF0)      w_next_state = ST_BRK;
                    else if (i_scan_code == 8'hE0) w_next_state = ST_EXT;
                    else if (i_scan_code == 8'h12) w_set_lshift = 1'b1;
                    else if (i_scan_code == 8'h59) w_set_rshift = 1'b1;
`ifdef KB_CAPS_LOCK_EN
                    else if (i_scan_code == 8'h58) w_caps_make  = 1'b1;
`endif
                    else                           w_load_key   = 1'b1;
                end
                ST_BRK: begin
                    if (i_scan_code == 8'h12)      w_clr_lshift = 1'b1;
                    else if (i_scan_code == 8'h59) w_clr_rshift = 1'b1;
`ifdef KB_CAPS_LOCK_EN
                    else if (i_scan_code == 8'h58) w_caps_brk   = 1'b1;
`endif
                    w_next_state = ST_IDLE;
                end
                ST_EXT: begin
                    if (i_scan_code == 8'hF0) w_next_state = ST_EXT_BRK;
                    else                      w_next_state = ST_IDLE;
                end
                default: w_next_state = ST_IDLE;
            endcase
        end
    end

    // State, modifier flags and the key code presented to the mapper.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= ST_IDLE;
            r_lshift    <= 1'b0;
            r_rshift    <= 1'b0;
            r_push_pend <= 1'b0;
            r_key_code  <= 8'h00;
        end else begin
            r_state     <= w_next_state;
            r_push_pend <= w_load_key;
            if (w_load_key)   r_key_code <= i_scan_code;
            if (w_set_lshift) r_lshift   <= 1'b1;
            if (w_clr_lshift) r_lshift   <= 1'b0;
            if (w_set_rshift) r_rshift   <= 1'b1;
            if (w_clr_rshift) r_rshift   <= 1'b0;
        end
    end

`ifdef KB_CAPS_LOCK_EN
    // Caps lock toggles once per physical press; typematic repeats are held off by caps_held.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_caps      <= 1'b0;
            r_caps_held <= 1'b0;
        end else begin
            if (w_caps_make) begin
                if (!r_caps_held) r_caps <= ~r_caps;
                r_caps_held <= 1'b1;
            end
            if (w_caps_brk) r_caps_held <= 1'b0;
        end
    end

    assign w_shift = (r_lshift | r_rshift) ^ r_caps;
`else
    assign w_shift = r_lshift | r_rshift;
`endif

    // The mapper yields uppercase letters; fold them to lowercase when unshifted.
    assign w_push_data = (!w_shift && i_ascii_code >= 8'h41 && i_ascii_code <= 8'h5A)
                       ? i_ascii_code + 8'h20 : i_ascii_code;

    assign w_empty = (r_count == CNT_EMPTY);
    assign w_full  = (r_count == CNT_FULL);
    assign w_pop   = i_rd && !w_empty;
    // A pop in the same cycle makes room, so a push into a full FIFO still lands.
    assign w_push  = r_push_pend && (!w_full || w_pop);
    assign w_drop  = r_push_pend && w_full && !w_pop;

    // FIFO storage; no reset needed because the output is gated by empty.
    always_ff @(posedge i_clk) begin
        if (!i_reset && w_push) r_mem[r_wr_ptr] <= w_push_data;
    end

    // FIFO pointers, occupancy and sticky overflow.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
            if (w_push && !w_pop)      r_count <= r_count + CNT_ONE;
            else if (!w_push && w_pop) r_count <= r_count - CNT_ONE;
            if (w_drop) r_overflow <= 1'b1;
        end
    end

    assign o_key_code = r_key_code;
    assign o_ascii    = w_empty ? 8'h00 : r_mem[r_rd_ptr];
    assign o_empty    = w_empty;
    assign o_full     = w_full;
    assign o_overflow = r_overflow;

endmodule

// File: doc/kb_scan_controller.md
# kb_scan_controller

Sequencing controller between the PS2 receiver and the combinational scan-code-to-ASCII mapper in the keyboard path. Consumes raw Set-2 scan-code bytes and tracks make/break/extended prefixes and shift state. Presents each make code to the mapper, applies letter case, and buffers the resulting characters in a small show-ahead FIFO for the consumer (UART transmitter, text display).

## Interface
- `FIFO_ADDR_W`, default 2: FIFO depth is 2^FIFO_ADDR_W entries (4 by default).
- `i_clk`  in  1  system clock, rising edge.
- `i_reset`  in  1  synchronous, active-high reset.
- `i_scan_code`  in  8  byte from the PS2 receiver; valid only with `i_scan_done`.
- `i_scan_done`  in  1  one-cycle strobe, one received byte.
- `o_key_code`  out  8  registered make code driven to the mapper's key-code input.
- `i_ascii_code`  in  8  mapper output for `o_key_code`, combinational.
- `i_rd`  in  1  pop request; removes the FIFO head.
- `o_ascii`  out  8  FIFO head; valid while `o_empty`=0.
- `o_empty`  out  1  FIFO empty.
- `o_full`  out  1  FIFO full.
- `o_overflow`  out  1  sticky: a character was dropped because the FIFO was full.

## Operation
- **States.** IDLE, BRK (F0 seen), EXT (E0 seen), EXT_BRK (E0 F0 seen). Bytes are processed only on `i_scan_done`. The state does not change between strobes.
- **IDLE:**
  - 0xF0 -> BRK.
  - 0xE0 -> EXT.
  - 0x12 sets `lshift`; 0x59 sets `rshift`. No push.
  - Any other byte is a make: load it into `o_key_code` and set `push_pend`. Stay in IDLE.
  - Typematic repeats are ordinary makes; each one pushes.
- **BRK:** next byte 0x12 clears `lshift`; 0x59 clears `rshift`; any other byte is ignored. -> IDLE. No push.
- **EXT:** 0xF0 -> EXT_BRK. Any other byte is discarded (extended keys produce no character). -> IDLE.
- **EXT_BRK:** next byte discarded. -> IDLE.
- **Push.** In the cycle after a make is loaded, `i_ascii_code` is case-adjusted and written to the FIFO. Let shift = `lshift` | `rshift` (XOR caps when configured).
  - Value in 0x41..0x5A with shift=0: write the value + 0x20 (lowercase).
  - Otherwise: write the value unchanged. Digits, punctuation, 0x0D, 0x08 and 0x2A are unaffected by shift.
- **FIFO push when full:** dropped, `o_overflow` set to 1 (cleared only by reset). Exception: a pop in the same cycle frees space, and the push succeeds.
- **Pop.** `i_rd` with `o_empty`=1 is ignored. Simultaneous push and pop when not empty: both occur, count unchanged.
- **Pointers.** FIFO_ADDR_W-bit read/write pointers wrap modulo depth. Full/empty come from an extra wrap bit or an occupancy counter.
- **Reset values:**
  - state IDLE; `lshift`/`rshift`/`caps` 0; `push_pend` 0.
  - `o_key_code` 0x00; FIFO empty; `o_empty` 1; `o_full` 0; `o_overflow` 0; `o_ascii` 0x00.

## Timing
- **Latency.** A make strobed in the cycle before edge E0 loads `o_key_code` at E0 and is written at E1. `o_empty` falls and `o_ascii` is valid after E1: 2 edges from strobe to visible.
- **Throughput.** Strobes may arrive every cycle. Each make is written one edge after loading, independent of the next byte.
- **Pop.** `i_rd` sampled at edge E advances the head. The new `o_ascii` / `o_empty` are valid after E.
- **Reset priority.** Reset overrides everything, including a pending push and a strobe in the same cycle. Reset mid-sequence (e.g. after F0) returns to IDLE with no push.

## Configuration
- **`KB_CAPS_LOCK_EN` defined:**
  - In IDLE, make 0x58 toggles `caps` only if `caps_held`=0, then sets `caps_held`. No push; repeats do not re-toggle.
  - Break 0x58 clears `caps_held`.
  - Letter case uses (`lshift` | `rshift`) XOR `caps`.
- **Undefined:** no `caps` / `caps_held` registers. 0x58 is an ordinary make and pushes the mapper's output (0x2A). Case uses shift only.

## Test plan
- After reset: strobe 0x1C -> after 2 edges `o_empty`=0, `o_ascii`=0x61. Then strobe F0,1C -> no further push.
- Strobe 12, 1C, F0 1C, F0 12, 1C -> FIFO contents 0x41 then 0x61. Strobe 59, 16 -> 0x31 (digit unaffected by shift).
- Strobe E0 75, E0 F0 75, then 5A, 66 -> only 0x0D, 0x08 queued. `o_key_code` never equals 0x75.
- Default depth: 5 makes of 0x1C with no pops -> `o_full`=1 after the 4th, 5th dropped, `o_overflow`=1. Pop 4 times -> 0x61 ×4, `o_empty`=1, `o_overflow` still 1. Also drive a make write together with a pop while full -> count stays 4, no overflow.
- Reset asserted the cycle after F0 with a make pending -> FIFO empty, `o_key_code`=0x00. Next strobe 0x1C is treated as a make (0x61).
- With `KB_CAPS_LOCK_EN`: strobe 58, 58 (repeat), F0 58, 1C -> 0x41; then 12, 1C -> 0x61. Without the macro: strobe 58 -> 0x2A queued.
